// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_pkg
// Description : Shared types and constants for the full-adder slice.
//               - fa_result_t   : packed {carry, sum} pair. Read as a 2-bit
//                                 value it equals a + b + carry_in.
//               - C_RESULT_ZERO : the reset value of the registered result.
// Revision    : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

    typedef struct packed {
        logic carry;
        logic sum;
    } fa_result_t;

    localparam fa_result_t C_RESULT_ZERO = '{carry: 1'b0, sum: 1'b0};

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_core.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_core
// Description : Purely combinational one-bit full adder.
// Ports       : a         (in)  addend bit
//               b         (in)  addend bit
//               carry_in  (in)  carry input
//               sum       (out) a ^ b ^ carry_in
//               carry_out (out) majority(a, b, carry_in)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_core (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    // The half-sum is shared by both outputs. The carry uses the
    // generate/propagate form: generate is (a & b), and propagate
    // passes carry_in through whenever exactly one addend bit is set.
    logic w_half_sum;

    assign w_half_sum = a ^ b;
    assign sum        = w_half_sum ^ carry_in;
    assign carry_out  = (a & b) | (carry_in & w_half_sum);

endmodule : full_adder_core
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Full adder with a zero-latency combinational result, a
//               one-cycle registered result qualified by in_valid, and a
//               saturating count of accepted operations.
// Ports       : clk         (in)  clock; every register updates on its rising edge
//               rst_n       (in)  synchronous active-low reset
//               a, b        (in)  addend bits
//               carry_in    (in)  carry input
//               in_valid    (in)  qualifies a/b/carry_in for the registered path
//               sum         (out) combinational sum
//               carry_out   (out) combinational carry
//               sum_q       (out) registered sum
//               carry_out_q (out) registered carry
//               out_valid   (out) sum_q/carry_out_q were updated on the last edge
//               op_count    (out) accepted operations; saturates at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    localparam int C_DEFAULT_CNT_W = 16,
    parameter  int CNT_W           = C_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic             sum,
    output logic             carry_out,
    output logic             sum_q,
    output logic             carry_out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Combinational adder. It has no path from clk, rst_n or in_valid,
    // so sum and carry_out follow the inputs even while reset is held.
    // ------------------------------------------------------------------
    logic w_sum;
    logic w_carry;

    full_adder_core u_core (
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

    assign sum       = w_sum;
    assign carry_out = w_carry;

    // ------------------------------------------------------------------
    // Registered result path
    // ------------------------------------------------------------------
    fa_result_t r_res_q;
    fa_result_t w_res_d;
    logic       r_valid_q;
    logic       w_valid_d;

    // With in_valid low the previous result is held. out_valid drops, so
    // downstream logic can tell a held result from a new one.
    always_comb begin
        w_res_d   = r_res_q;
        w_valid_d = 1'b0;
        if (in_valid) begin
            w_res_d   = '{carry: w_carry, sum: w_sum};
            w_valid_d = 1'b1;
        end
    end

    // Reset has priority, so an operation presented in the reset cycle
    // is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_q   <= C_RESULT_ZERO;
            r_valid_q <= 1'b0;
        end else begin
            r_res_q   <= w_res_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign sum_q       = r_res_q.sum;
    assign carry_out_q = r_res_q.carry;
    assign out_valid   = r_valid_q;

    // ------------------------------------------------------------------
    // Saturating operation counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;
    logic             w_count_full;

    // The counter stops at all-ones instead of wrapping, so a long stream
    // can never read back as a small count.
    assign w_count_full = &r_count_q;

    always_comb begin
        w_count_d = r_count_q;
        if (in_valid && !w_count_full) begin
            w_count_d = r_count_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count_q <= C_CNT_ZERO;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign op_count = r_count_q;

endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Self-checking bench for full_adder. It runs an exhaustive
//               table of combinational vectors, then directed sequences for
//               the pipeline, reset priority, counting, saturation (on a
//               second instance with CNT_W=2) and mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    logic        clk;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        carry_in;
    logic        in_valid;

    logic        sum;
    logic        carry_out;
    logic        sum_q;
    logic        carry_out_q;
    logic        out_valid;
    logic [15:0] op_count;

    logic        s_sum;
    logic        s_carry_out;
    logic        s_sum_q;
    logic        s_carry_out_q;
    logic        s_out_valid;
    logic [1:0]  s_op_count;

    int n_total;
    int n_pass;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_co;
        logic exp_s;
    } vec_t;

    vec_t vecs [8];

    full_adder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .in_valid    (in_valid),
        .sum         (sum),
        .carry_out   (carry_out),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q),
        .out_valid   (out_valid),
        .op_count    (op_count)
    );

    full_adder #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .in_valid    (in_valid),
        .sum         (s_sum),
        .carry_out   (s_carry_out),
        .sum_q       (s_sum_q),
        .carry_out_q (s_carry_out_q),
        .out_valid   (s_out_valid),
        .op_count    (s_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input logic vc, input logic vv);
        a        = va;
        b        = vb;
        carry_in = vc;
        in_valid = vv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_arith;
        int         exp_cnt;
        int         exp_sat;
        logic [2:0] pat;

        n_total = 0;
        n_pass  = 0;

        // {a, b, carry_in, expected carry_out, expected sum}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        chk("reset sum_q",       {31'd0, sum_q},       32'd0);
        chk("reset carry_out_q", {31'd0, carry_out_q}, 32'd0);
        chk("reset out_valid",   {31'd0, out_valid},   32'd0);
        chk("reset op_count",    {16'd0, op_count},    32'd0);
        chk("reset sat count",   {30'd0, s_op_count},  32'd0);

        // Exhaustive combinational table. rst_n toggles between vectors
        // to show the combinational outputs ignore reset.
        for (int i = 0; i < 8; i++) begin
            rst_n = i[0];
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            #10;
            chk($sformatf("comb sum[%0d]", i),  {31'd0, sum},       {31'd0, vecs[i].exp_s});
            chk($sformatf("comb cout[%0d]", i), {31'd0, carry_out}, {31'd0, vecs[i].exp_co});
        end

        // Pipeline: one valid 1+1+1 operation
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("pipe out_valid",   {31'd0, out_valid},   32'd1);
        chk("pipe sum_q",       {31'd0, sum_q},       32'd1);
        chk("pipe carry_out_q", {31'd0, carry_out_q}, 32'd1);
        chk("pipe op_count",    {16'd0, op_count},    32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("idle out_valid",   {31'd0, out_valid},   32'd0);
        chk("idle sum_q hold",  {31'd0, sum_q},       32'd1);
        chk("idle cout_q hold", {31'd0, carry_out_q}, 32'd1);
        chk("idle comb sum",    {31'd0, sum},         32'd0);
        chk("idle op_count",    {16'd0, op_count},    32'd1);

        // Reset priority over in_valid
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk("rstpri sum_q",     {31'd0, sum_q},       32'd0);
        chk("rstpri cout_q",    {31'd0, carry_out_q}, 32'd0);
        chk("rstpri out_valid", {31'd0, out_valid},   32'd0);
        chk("rstpri op_count",  {16'd0, op_count},    32'd0);
        chk("rstpri comb sum",  {31'd0, sum},         32'd1);
        chk("rstpri comb cout", {31'd0, carry_out},   32'd0);

        // Counting: 5 valid, 2 idle, 3 valid. Registered results are
        // checked against arithmetic addition; the CNT_W=2 instance must
        // stop at 3.
        rst_n   = 1'b1;
        exp_cnt = 0;
        exp_sat = 0;
        for (int k = 0; k < 10; k++) begin
            pat = 3'(k * 3 + 1);
            if (k == 5 || k == 6) begin
                drive(pat[2], pat[1], pat[0], 1'b0);
            end else begin
                drive(pat[2], pat[1], pat[0], 1'b1);
            end
            step();
            if (k != 5 && k != 6) begin
                exp_cnt++;
                if (exp_sat < 3) exp_sat++;
                exp_arith = 2'(pat[2]) + 2'(pat[1]) + 2'(pat[0]);
                chk($sformatf("cnt sum_q[%0d]", k),  {31'd0, sum_q},       {31'd0, exp_arith[0]});
                chk($sformatf("cnt cout_q[%0d]", k), {31'd0, carry_out_q}, {31'd0, exp_arith[1]});
                chk($sformatf("cnt valid[%0d]", k),  {31'd0, out_valid},   32'd1);
            end else begin
                chk($sformatf("cnt idle valid[%0d]", k), {31'd0, out_valid}, 32'd0);
            end
            chk($sformatf("sat count[%0d]", k), {30'd0, s_op_count}, 32'(exp_sat));
        end
        chk("count total 8",  {16'd0, op_count},   32'd8);
        chk("sat stays at 3", {30'd0, s_op_count}, 32'd3);

        // Mid-stream reset: 4 more valid cycles, a one-cycle reset with
        // in_valid still high, then one valid cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            step();
        end
        chk("pre-reset count", {16'd0, op_count}, 32'd12);
        rst_n = 1'b0;
        step();
        chk("midrst op_count",  {16'd0, op_count},    32'd0);
        chk("midrst sum_q",     {31'd0, sum_q},       32'd0);
        chk("midrst cout_q",    {31'd0, carry_out_q}, 32'd0);
        chk("midrst out_valid", {31'd0, out_valid},   32'd0);
        chk("midrst sat count", {30'd0, s_op_count},  32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk("resume op_count",  {16'd0, op_count},    32'd1);
        chk("resume out_valid", {31'd0, out_valid},   32'd1);
        chk("resume sum_q",     {31'd0, sum_q},       32'd1);
        chk("resume cout_q",    {31'd0, carry_out_q}, 32'd0);
        chk("resume sat count", {30'd0, s_op_count},  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_full_adder
`default_nettype wire
